regfile_wr_arbiter: RTL and testbench

- Shares the single write port of the 32 x 32-bit register file between NREQ requesters, e.g. pipeline writeback, multdiv unit and keyboard/IO input.
- Each cycle, picks one pending request by round-robin and drives a registered write (enable/address/data) into the regfile.
- Returns a one-cycle grant pulse to the winner.
- Writes to $r0 are acknowledged but suppressed.

---
 rtl/regfile_wr_arbiter_if.sv | 32 +++
 rtl/regfile_wr_arbiter.sv | 105 ++++++++++
 tb/tb_regfile_wr_arbiter.sv | 116 +++++++++++
 3 files changed

// File: rtl/regfile_wr_arbiter_if.sv
// Write-port bus between the requesters and the regfile write arbiter.
//
// Handshake: a requester raises req[i] with stable req_addr/req_data slices
// and holds them until it sees grant[i] high for one cycle. In that grant
// cycle it may drop req[i] or present a new item. The new item becomes
// eligible at the following clock edge.
interface regfile_wr_arbiter_if #(
    parameter int NREQ   = 3,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic [NREQ-1:0]        req;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        grant;
    logic                   wr_en;
    logic [ADDR_W-1:0]      wr_addr;
    logic [DATA_W-1:0]      wr_data;
    logic                   busy;

    // Requester side drives requests and observes grants and the write port.
    modport master (
        output req, req_addr, req_data,
        input  grant, wr_en, wr_addr, wr_data, busy
    );

    // Arbiter side.
    modport slave (
        input  req, req_addr, req_data,
        output grant, wr_en, wr_addr, wr_data, busy
    );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter.
// Picks one pending requester per cycle and drives a registered write into
// the 32 x 32 regfile. Writes to $r0 are granted but wr_en stays low.
// The default build uses round-robin priority. Defining ARB_FIXED_PRIO_EN
// removes the rotating pointer, and requester 0 then always has the
// highest priority.
module regfile_wr_arbiter #(
    parameter int NREQ   = 3,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    regfile_wr_arbiter_if.slave   bus
);

`ifndef ARB_FIXED_PRIO_EN
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  ptr_nxt;
`endif

    logic [NREQ-1:0]   grant_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;

    logic [NREQ-1:0]   eff;
    logic              found;
    logic [NREQ-1:0]   gnt_nxt;
    logic [ADDR_W-1:0] addr_sel;
    logic [DATA_W-1:0] data_sel;

    // A requester granted this cycle is masked so a held req is not served twice.
    assign eff = bus.req & ~grant_q;

    // More than one eligible request means somebody has to wait.
    assign bus.busy = |(eff & (eff - NREQ'(1)));

    // Pick the winner. Round-robin first scans from ptr upward, then wraps to index 0.
    always_comb begin
        found    = 1'b0;
        gnt_nxt  = '0;
        addr_sel = '0;
        data_sel = '0;
`ifndef ARB_FIXED_PRIO_EN
        ptr_nxt  = ptr;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && eff[i] && (i >= int'(ptr))) begin
                found      = 1'b1;
                gnt_nxt[i] = 1'b1;
                addr_sel   = bus.req_addr[i*ADDR_W +: ADDR_W];
                data_sel   = bus.req_data[i*DATA_W +: DATA_W];
                ptr_nxt    = (i == NREQ - 1) ? '0 : PTR_W'(i + 1);
            end
        end
`endif
        for (int i = 0; i < NREQ; i++) begin
            if (!found && eff[i]) begin
                found      = 1'b1;
                gnt_nxt[i] = 1'b1;
                addr_sel   = bus.req_addr[i*ADDR_W +: ADDR_W];
                data_sel   = bus.req_data[i*DATA_W +: DATA_W];
`ifndef ARB_FIXED_PRIO_EN
                ptr_nxt    = (i == NREQ - 1) ? '0 : PTR_W'(i + 1);
`endif
            end
        end
    end

    // Register grant and write port. Address and data hold when the cycle is idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else if (found) begin
            grant_q   <= gnt_nxt;
            wr_en_q   <= |addr_sel;
            wr_addr_q <= addr_sel;
            wr_data_q <= data_sel;
        end else begin
            grant_q   <= '0;
            wr_en_q   <= 1'b0;
        end
    end

`ifndef ARB_FIXED_PRIO_EN
    // The pointer moves one past the winner and holds when the cycle is idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_nxt;
        end
    end
`endif

    assign bus.grant   = grant_q;
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter. Each step pushes the expected
// write-port result, and the next rising edge pops it for comparison.
module tb_regfile_wr_arbiter;
    localparam int NREQ   = 3;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int EW     = NREQ + 1 + ADDR_W + DATA_W;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    regfile_wr_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    regfile_wr_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock and reset
    always #5 clk = ~clk;

    logic [EW-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Driver: called while clk is low, compares one rising edge later, returns at the next negedge.
    task automatic step(input string tag, input logic [2:0] r,
                        input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                        input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                        input logic eb, input logic [2:0] eg, input logic ewe,
                        input logic [4:0] ea, input logic [31:0] ed);
        logic [EW-1:0] e;
        bus.req      = r;
        bus.req_addr = {a2, a1, a0};
        bus.req_data = {d2, d1, d0};
        exp_q.push_back({eg, ewe, ea, ed});
        #1;
        check({tag, "_busy"}, 64'(bus.busy), 64'(eb));
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check({tag, "_grant"}, 64'(bus.grant),   64'(e[EW-1 -: NREQ]));
        check({tag, "_wr_en"}, 64'(bus.wr_en),   64'(e[ADDR_W+DATA_W]));
        check({tag, "_addr"},  64'(bus.wr_addr), 64'(e[ADDR_W+DATA_W-1 -: ADDR_W]));
        check({tag, "_data"},  64'(bus.wr_data), 64'(e[DATA_W-1:0]));
        @(negedge clk);
    endtask

    initial begin
        bus.req      = '0;
        bus.req_addr = '0;
        bus.req_data = '0;
        #12;
        check("rst_grant", 64'(bus.grant),   64'd0);
        check("rst_wr_en", 64'(bus.wr_en),   64'd0);
        check("rst_addr",  64'(bus.wr_addr), 64'd0);
        check("rst_data",  64'(bus.wr_data), 64'd0);
        check("rst_busy",  64'(bus.busy),    64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Single requester, then the held req is masked for one cycle.
        step("single",   3'b001, 5, 0, 0, 32'hAA, 0, 0, 1'b0, 3'b001, 1'b1, 5'd5, 32'hAA);
        step("masked",   3'b001, 5, 0, 0, 32'hAA, 0, 0, 1'b0, 3'b000, 1'b0, 5'd5, 32'hAA);
        step("to_r2",    3'b100, 0, 0, 7, 0, 0, 32'h77, 1'b0, 3'b100, 1'b1, 5'd7, 32'h77);
        step("idle0",    3'b000, 0, 0, 0, 0, 0, 0, 1'b0, 3'b000, 1'b0, 5'd7, 32'h77);

`ifndef ARB_FIXED_PRIO_EN
        // All three held with ptr at 0: served in rotating order.
        step("rr0", 3'b111, 1, 2, 3, 32'h11, 32'h22, 32'h33, 1'b1, 3'b001, 1'b1, 5'd1, 32'h11);
        step("rr1", 3'b111, 1, 2, 3, 32'h11, 32'h22, 32'h33, 1'b1, 3'b010, 1'b1, 5'd2, 32'h22);
        step("rr2", 3'b111, 1, 2, 3, 32'h11, 32'h22, 32'h33, 1'b1, 3'b100, 1'b1, 5'd3, 32'h33);
        step("rr3", 3'b111, 1, 2, 3, 32'h11, 32'h22, 32'h33, 1'b1, 3'b001, 1'b1, 5'd1, 32'h11);
        step("idle1", 3'b000, 0, 0, 0, 0, 0, 0, 1'b0, 3'b000, 1'b0, 5'd1, 32'h11);
`else
        // Fixed priority: requester 1 re-presents on every grant.
        step("fp0", 3'b110, 0, 1, 2, 0, 32'h11, 32'h22, 1'b1, 3'b010, 1'b1, 5'd1, 32'h11);
        step("fp1", 3'b110, 0, 1, 2, 0, 32'h11, 32'h22, 1'b0, 3'b100, 1'b1, 5'd2, 32'h22);
        step("fp2", 3'b110, 0, 1, 2, 0, 32'h11, 32'h22, 1'b0, 3'b010, 1'b1, 5'd1, 32'h11);
        step("idle1", 3'b000, 0, 0, 0, 0, 0, 0, 1'b0, 3'b000, 1'b0, 5'd1, 32'h11);
`endif

        // Write to $r0: granted and data latched, but wr_en stays low.
        step("r0",      3'b010, 0, 0, 0, 0, 32'hFFFF_FFFF, 0, 1'b0, 3'b010, 1'b0, 5'd0, 32'hFFFF_FFFF);
        step("r2",      3'b100, 0, 0, 9, 0, 0, 32'h99, 1'b0, 3'b100, 1'b1, 5'd9, 32'h99);
        // After requester 2, the pointer wraps back to requester 0.
        step("wrap0",   3'b101, 4, 0, 10, 32'h44, 0, 32'hA0, 1'b0, 3'b001, 1'b1, 5'd4, 32'h44);
        step("wrap1",   3'b101, 4, 0, 10, 32'h44, 0, 32'hA0, 1'b0, 3'b100, 1'b1, 5'd10, 32'hA0);
        step("idle2",   3'b000, 0, 0, 0, 0, 0, 0, 1'b0, 3'b000, 1'b0, 5'd10, 32'hA0);
        step("pre_rst", 3'b010, 0, 12, 0, 0, 32'hC0FFEE, 0, 1'b0, 3'b010, 1'b1, 5'd12, 32'hC0FFEE);

        // Asynchronous reset while grant=010 and wr_en=1.
        reset = 1'b0;
        #1;
        check("mid_rst_grant", 64'(bus.grant),   64'd0);
        check("mid_rst_wr_en", 64'(bus.wr_en),   64'd0);
        check("mid_rst_addr",  64'(bus.wr_addr), 64'd0);
        check("mid_rst_data",  64'(bus.wr_data), 64'd0);
        #1;
        reset = 1'b1;
        step("post_rst", 3'b010, 0, 12, 0, 0, 32'hC0FFEE, 0, 1'b0, 3'b010, 1'b1, 5'd12, 32'hC0FFEE);

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
